// File: rtl/str_grid_transpose_buffer.sv
// Block transpose buffer: accepts a ROWS x COLS grid in row-major order, then
// presents it one column per handshake (row r of the column at bits [r*WIDTH +: WIDTH]).
module str_grid_transpose_buffer #(
  parameter  int unsigned ROWS  = 4,
  parameter  int unsigned COLS  = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROWS*WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_col,
  output logic                  out_last
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_wr_row;
  logic [RW-1:0]   w_wr_row_nxt;
  logic [CW-1:0]   r_wr_col;
  logic [CW-1:0]   w_wr_col_nxt;
  logic [CW-1:0]   r_rd_col;
  logic [CW-1:0]   w_rd_col_nxt;
  logic            w_wr_en;
  logic            w_last_row;
  logic            w_last_col;
  logic            w_rd_last;
  logic [WIDTH-1:0] w_grid [ROWS][COLS];

  assign w_last_row = (r_wr_row == RW'(ROWS - 1));
  assign w_last_col = (r_wr_col == CW'(COLS - 1));
  assign w_rd_last  = (r_rd_col == CW'(COLS - 1));

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FILL;
      r_wr_row <= '0;
      r_wr_col <= '0;
      r_rd_col <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_row <= w_wr_row_nxt;
      r_wr_col <= w_wr_col_nxt;
      r_rd_col <= w_rd_col_nxt;
    end
  end

  // Next-state and counter update; flush overrides any same-cycle transfer
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_row_nxt = r_wr_row;
    w_wr_col_nxt = r_wr_col;
    w_rd_col_nxt = r_rd_col;
    w_wr_en      = 1'b0;
    if (flush) begin
      w_state_nxt  = S_FILL;
      w_wr_row_nxt = '0;
      w_wr_col_nxt = '0;
      w_rd_col_nxt = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            w_wr_en = 1'b1;
            if (w_last_col) begin
              w_wr_col_nxt = '0;
              if (w_last_row) begin
                w_wr_row_nxt = '0;
                w_rd_col_nxt = '0;
                w_state_nxt  = S_DRAIN;
              end else begin
                w_wr_row_nxt = r_wr_row + RW'(1);
              end
            end else begin
              w_wr_col_nxt = r_wr_col + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (w_rd_last) begin
              w_rd_col_nxt = '0;
              w_state_nxt  = S_FILL;
            end else begin
              w_rd_col_nxt = r_rd_col + CW'(1);
            end
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  // One register per grid cell
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic [WIDTH-1:0] r_cell;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cell <= '0;
        end else if (w_wr_en && (r_wr_row == RW'(gr)) && (r_wr_col == CW'(gc))) begin
          r_cell <= in_data;
        end
      end
      assign w_grid[gr][gc] = r_cell;
    end
  end

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_DRAIN);
  assign out_col   = (r_state == S_DRAIN) ? r_rd_col : '0;
  assign out_last  = (r_state == S_DRAIN) && w_rd_last;

  // Column select; zero while filling
  always_comb begin
    out_data = '0;
    if (r_state == S_DRAIN) begin
      for (int r = 0; r < ROWS; r++) begin
        out_data[r*WIDTH +: WIDTH] = w_grid[r][r_rd_col];
      end
    end
  end

endmodule

// File: doc/str_grid_transpose_buffer.md
STR_GRID_TRANSPOSE_BUFFER -- requirements
Module: str_grid_transpose_buffer

Interface
REQ-001 SHALL have parameter ROWS, default 4, grid row count (>=1).
REQ-002 SHALL have parameter COLS, default 4, grid column count (>=1).
REQ-003 SHALL have parameter WIDTH, default 8, bits per grid cell (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port flush  input  1  synchronous abort of the current block.
REQ-007 SHALL have port in_valid  input  1  in_data holds a valid word.
REQ-008 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  input word, row-major order.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid column.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the column.
REQ-012 SHALL have port out_data  output  ROWS*WIDTH  column; row r at bits [r*WIDTH +: WIDTH].
REQ-013 SHALL have port out_col  output  CW=max(1,$clog2(COLS))  index of the presented column.
REQ-014 SHALL have port out_last  output  1  presented column is column COLS-1.

Function
REQ-015 SHALL hold a ROWS x COLS grid of WIDTH-bit registers, one per cell, built with nested row/column generate loops.
REQ-016 SHALL implement FSM with states FILL and DRAIN only.
REQ-017 SHALL in FILL drive in_ready=1 and out_valid=0; in DRAIN drive in_ready=0 and out_valid=1.
REQ-018 SHALL on an input transfer (in_valid & in_ready) write in_data to grid[wr_row][wr_col], then advance wr_col, wrapping to 0 and incrementing wr_row at COLS-1.
REQ-019 SHALL on the transfer into cell [ROWS-1][COLS-1] move to DRAIN next cycle with rd_col=0 and wr_row=wr_col=0.
REQ-020 SHALL ignore in_data whenever in_ready=0 (no cell write, no counter change).
REQ-021 SHALL in DRAIN drive out_data from grid[r][rd_col] for all r, out_col=rd_col, out_last=(rd_col==COLS-1).
REQ-022 SHALL on an output transfer (out_valid & out_ready) increment rd_col; on transfer with out_last=1 return to FILL next cycle.
REQ-023 SHALL keep out_data, out_col, out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL present column 0 in the cycle after the final input word is accepted (latency 1).
REQ-025 SHALL not overlap fill and drain; one block costs ROWS*COLS + COLS handshake cycles minimum.
REQ-026 SHALL, when flush=1, go to FILL with all counters 0 next cycle, overriding any same-cycle input or output transfer; grid contents unchanged, partial block discarded.
REQ-027 SHALL drive out_data, out_col and out_last to 0 while in FILL.
REQ-028 SHALL, for ROWS=1 or COLS=1, operate identically with the corresponding counter held at 0.

Reset
REQ-029 SHALL on rst_n=0 immediately clear all grid cells, wr_row, wr_col, rd_col to 0 and enter FILL, independent of clk.
REQ-030 SHALL have reset outputs: in_ready=1, out_valid=0, out_data=0, out_col=0, out_last=0.
REQ-031 SHALL on reset mid-fill or mid-drain discard the block; first transfer after rst_n release writes cell [0][0].

Verification (ROWS=COLS=4, WIDTH=8 unless noted)
REQ-032 SHALL cover basic transpose: feed 0x00..0x0F back-to-back, out_ready=1 -> out_data 32'h0C080400, 32'h0D090501, 32'h0E0A0602, 32'h0F0B0703 on 4 consecutive cycles, out_last only on the 4th, in_ready=1 on the following cycle.
REQ-033 SHALL cover backpressure: hold out_ready=0 for 5 cycles at column 1 -> out_data stays 32'h0D090501, out_col=1, in_ready=0 throughout, in_valid words ignored.
REQ-034 SHALL cover input bubbles: toggle in_valid every other cycle -> same four columns as REQ-032, DRAIN entered 1 cycle after 16th accepted word.
REQ-035 SHALL cover flush: flush after 7 words, then feed 0x10..0x1F -> column 0 = 32'h1C181410.
REQ-036 SHALL cover flush during DRAIN at column 2 with out_ready=1 -> no column-2 transfer counted, in_ready=1 next cycle.
REQ-037 SHALL cover async reset mid-drain plus ROWS=1,COLS=3,WIDTH=4: rst_n low between clock edges -> out_valid=0 immediately; then words 0x1,0x2,0x3 -> out_data 0x1,0x2,0x3, out_col 0,1,2.
